// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin front end for a single-port synchronous SRAM macro.
// Grants are combinational; reads return in acceptance order two cycles after the grant.
module sram_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WORDS  = 20
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rsp_valid,
  output logic                  p0_rsp_err,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rsp_valid,
  output logic                  p1_rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_WORDS = (ADDR_WIDTH+1)'(NUM_WORDS);

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < LP_NUM_WORDS);
  endfunction

  logic                  r_prio;
  logic                  w_gnt0_p0;
  logic                  w_gnt1_p0;
  logic                  w_xfer_p0;
  logic                  w_we_p0;
  logic [ADDR_WIDTH-1:0] w_addr_p0;
  logic [DATA_WIDTH-1:0] w_wdata_p0;
  logic                  w_inr_p0;
  logic                  w_mem_p0;
  logic                  w_rd_p0;

  logic                  r_csb;
  logic                  r_web;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  r_vld_p1;
  logic                  r_id_p1;
  logic                  r_err_p1;
  logic                  r_vld_p2;
  logic                  r_id_p2;
  logic                  r_err_p2;

  logic                  r_rsp_vld0;
  logic                  r_rsp_vld1;
  logic                  r_rsp_err0;
  logic                  r_rsp_err1;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Stage p0: arbitration and request mux
  always_comb begin
    w_gnt0_p0  = !rst0 && p0_valid && (!p1_valid || !r_prio);
    w_gnt1_p0  = !rst0 && p1_valid && (!p0_valid ||  r_prio);
    w_xfer_p0  = w_gnt0_p0 || w_gnt1_p0;
    w_we_p0    = w_gnt1_p0 ? p1_we    : p0_we;
    w_addr_p0  = w_gnt1_p0 ? p1_addr  : p0_addr;
    w_wdata_p0 = w_gnt1_p0 ? p1_wdata : p0_wdata;
    w_inr_p0   = f_in_range(w_addr_p0);
    w_mem_p0   = w_xfer_p0 && w_inr_p0;
    w_rd_p0    = w_xfer_p0 && !w_we_p0;
  end

  assign p0_ready = w_gnt0_p0;
  assign p1_ready = w_gnt1_p0;

  // The loser of a transfer always wins the next contention.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_prio <= 1'b0;
    end else if (w_xfer_p0) begin
      r_prio <= w_gnt0_p0;
    end
  end

  // Stage p1: SRAM command registers and response tag
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_csb  <= 1'b1;
      r_web  <= 1'b1;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_csb <= !w_mem_p0;
      if (w_mem_p0) begin
        r_web  <= !w_we_p0;
        r_addr <= w_addr_p0;
        r_din  <= w_wdata_p0;
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_vld_p1 <= 1'b0;
      r_id_p1  <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_p0;
      r_id_p1  <= w_gnt1_p0;
      r_err_p1 <= !w_inr_p0;
    end
  end

  // Stage p2: macro is reading; its data is valid at the next edge
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_vld_p2 <= 1'b0;
      r_id_p2  <= 1'b0;
      r_err_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_id_p2  <= r_id_p1;
      r_err_p2 <= r_err_p1;
    end
  end

  // Response stage: capture dout0 and steer the strobe to the requester
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_rsp_vld0 <= 1'b0;
      r_rsp_vld1 <= 1'b0;
      r_rsp_err0 <= 1'b0;
      r_rsp_err1 <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rsp_vld0 <= r_vld_p2 && !r_id_p2;
      r_rsp_vld1 <= r_vld_p2 &&  r_id_p2;
      r_rsp_err0 <= r_vld_p2 && !r_id_p2 && r_err_p2;
      r_rsp_err1 <= r_vld_p2 &&  r_id_p2 && r_err_p2;
      if (r_vld_p2) begin
        r_rdata <= r_err_p2 ? '0 : dout0;
      end
    end
  end

  assign csb0         = r_csb;
  assign web0         = r_web;
  assign addr0        = r_addr;
  assign din0         = r_din;
  assign p0_rsp_valid = r_rsp_vld0;
  assign p1_rsp_valid = r_rsp_vld1;
  assign p0_rsp_err   = r_rsp_err0;
  assign p1_rsp_err   = r_rsp_err1;
  assign rsp_rdata    = r_rdata;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed scenarios plus random traffic against a
// queue-based reference model, with a behavioural SRAM macro attached.
module tb_sram_rr_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NW = 20;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  always #5 clk0 = ~clk0;

  sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .clk0(clk0), .rst0(rst0),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
    .rsp_rdata(rsp_rdata), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
    .dout0(dout0)
  );

  function automatic logic [DW-1:0] seed_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i * 7)};
  endfunction

  // SRAM macro: captures commands at the rising edge, commits writes at the falling edge.
  logic [DW-1:0] sram_mem [NW];
  logic          mem_init;
  logic          wr_pend;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;

  always @(posedge clk0) begin
    wr_pend <= 1'b0;
    if (!csb0) begin
      if (!web0) begin
        wr_pend <= 1'b1;
        wr_a    <= addr0;
        wr_d    <= din0;
      end else if (int'(addr0) < NW) begin
        dout0 <= sram_mem[addr0];
      end else begin
        dout0 <= 'x;
      end
    end
  end

  always @(negedge clk0) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= seed_word(i);
    end else if (wr_pend && int'(wr_a) < NW) begin
      sram_mem[wr_a] <= wr_d;
    end
  end

  // Reference model state
  typedef struct {
    int            port;
    logic          err;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] mem_m [32];
  int            prio_m;
  int            cyc;
  logic          exp_g0, exp_g1, obs_r0, obs_r1;
  logic          exp_csb, exp_web;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din, exp_rdata;
  logic          exp_v0, exp_v1, exp_e0, exp_e1;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prio_m    = 0;
    exp_csb   = 1'b1;
    exp_web   = 1'b1;
    exp_addr  = '0;
    exp_din   = '0;
    exp_rdata = '0;
    exp_v0    = 1'b0;
    exp_v1    = 1'b0;
    exp_e0    = 1'b0;
    exp_e1    = 1'b0;
  endtask

  task automatic check_outputs();
    chk1("csb0", csb0, exp_csb);
    chk1("web0", web0, exp_web);
    chka("addr0", addr0, exp_addr);
    chkd("din0", din0, exp_din);
    chk1("p0_rsp_valid", p0_rsp_valid, exp_v0);
    chk1("p1_rsp_valid", p1_rsp_valid, exp_v1);
    chk1("p0_rsp_err", p0_rsp_err, exp_e0);
    chk1("p1_rsp_err", p1_rsp_err, exp_e1);
    chkd("rsp_rdata", rsp_rdata, exp_rdata);
  endtask

  task automatic step(input logic v0, input logic we0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic v1, input logic we1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            port;
    logic          we, inr;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    rsp_t          r;
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    #1;
    exp_g0 = !rst0 && v0 && (!v1 || prio_m == 0);
    exp_g1 = !rst0 && v1 && (!v0 || prio_m == 1);
    obs_r0 = p0_ready;
    obs_r1 = p1_ready;
    chk1("p0_ready", obs_r0, exp_g0);
    chk1("p1_ready", obs_r1, exp_g1);
    @(posedge clk0);
    cyc++;
    exp_csb = 1'b1;
    if (exp_g0 || exp_g1) begin
      port   = exp_g1 ? 1 : 0;
      we     = port == 1 ? we1 : we0;
      a      = port == 1 ? a1 : a0;
      d      = port == 1 ? d1 : d0;
      prio_m = 1 - port;
      inr    = int'(a) < NW;
      if (inr) begin
        exp_csb  = 1'b0;
        exp_web  = !we;
        exp_addr = a;
        exp_din  = d;
        if (we) mem_m[a] = d;
      end
      if (!we) begin
        rd = inr ? mem_m[a] : '0;
        q.push_back('{port, !inr, rd, cyc + 2});
      end
    end
    exp_v0 = 1'b0; exp_v1 = 1'b0; exp_e0 = 1'b0; exp_e1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r         = q.pop_front();
      exp_v0    = r.port == 0;
      exp_v1    = r.port == 1;
      exp_e0    = r.port == 0 && r.err;
      exp_e1    = r.port == 1 && r.err;
      exp_rdata = r.data;
    end
    #1;
    check_outputs();
    @(negedge clk0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra0, ra1;
    rst0 = 1'b1; mem_init = 1'b1; cyc = 0;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = (i < NW) ? seed_word(i) : '0;
    #2;
    check_outputs();
    chk1("rst_p0_ready", p0_ready, 1'b0);
    chk1("rst_p1_ready", p1_ready, 1'b0);
    @(negedge clk0);
    @(negedge clk0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    #2 rst0 = 1'b0; mem_init = 1'b0;
    @(negedge clk0);

    // Write then read-back through the other port
    step(1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0);
    idle();
    idle();
    chk1("raw_p1_rsp_valid", p1_rsp_valid, 1'b1);
    chkd("raw_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk1("raw_p1_rsp_err", p1_rsp_err, 1'b0);
    idle();

    // Sustained contention alternates grants
    for (int i = 0; i < 6; i++) begin
      ra0 = AW'($urandom_range(NW - 1, 0));
      ra1 = AW'($urandom_range(NW - 1, 0));
      step(1'b1, 1'b0, ra0, '0, 1'b1, 1'b0, ra1, '0);
      chk1("alt_p0_grant", obs_r0, (i % 2) == 0);
    end
    repeat (3) idle();

    // Out-of-range accesses
    step(1'b1, 1'b0, 5'd20, '0, 1'b0, 1'b0, '0, '0);
    chk1("oor_csb_r20", csb0, 1'b1);
    step(1'b1, 1'b0, 5'd31, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 5'd25, 64'h1234, 1'b0, 1'b0, '0, '0);
    chk1("oor_csb_w25", csb0, 1'b1);
    chk1("oor_err_r20", p0_rsp_err, 1'b1);
    chkd("oor_rdata_r20", rsp_rdata, '0);
    idle();
    chk1("oor_err_r31", p0_rsp_err, 1'b1);
    idle();
    chk1("oor_w25_no_rsp", p0_rsp_valid, 1'b0);

    // Last word, back-to-back read after write
    step(1'b1, 1'b1, 5'd19, 64'h1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 5'd19, '0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();
    chk1("last_rsp_valid", p0_rsp_valid, 1'b1);
    chkd("last_rdata", rsp_rdata, 64'h1);
    idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)),
           {$urandom, $urandom},
           $urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)),
           {$urandom, $urandom});
    end
    repeat (3) idle();

    // Reset with reads in flight
    step(1'b1, 1'b0, 5'd5, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd6, '0);
    #2 rst0 = 1'b1;
    #1;
    model_reset();
    check_outputs();
    p0_valid = 1'b1; p1_valid = 1'b1;
    #1;
    chk1("inrst_p0_ready", p0_ready, 1'b0);
    chk1("inrst_p1_ready", p1_ready, 1'b0);
    @(posedge clk0);
    #1;
    check_outputs();
    @(negedge clk0);
    #2 rst0 = 1'b0;
    repeat (4) idle();
    step(1'b1, 1'b0, 5'd7, '0, 1'b1, 1'b0, 5'd8, '0);
    chk1("post_rst_p0_grant", obs_r0, 1'b1);
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: word width, matching the SRAM macro.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: SRAM address width.
REQ-003 SHALL have parameter NUM_WORDS, default 20: count of physically present words.
REQ-004 SHALL have port clk0, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst0, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports p0_valid and p1_valid, input, 1 bit each: requester N presents a request.
REQ-007 SHALL have ports p0_ready and p1_ready, output, 1 bit each: request accepted this cycle.
REQ-008 SHALL have ports p0_we and p1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-009 SHALL have ports p0_addr and p1_addr, input, ADDR_WIDTH each: word address.
REQ-010 SHALL have ports p0_wdata and p1_wdata, input, DATA_WIDTH each: write data.
REQ-011 SHALL have ports p0_rsp_valid and p1_rsp_valid, output, 1 bit each: one-cycle read response strobe.
REQ-012 SHALL have ports p0_rsp_err and p1_rsp_err, output, 1 bit each: response was to an out-of-range address.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH: read data, shared by both ports and qualified by pN_rsp_valid.
REQ-014 SHALL have port csb0, output, 1 bit: active-low SRAM chip select, registered.
REQ-015 SHALL have port web0, output, 1 bit: active-low SRAM write enable, registered.
REQ-016 SHALL have port addr0, output, ADDR_WIDTH: SRAM address, registered.
REQ-017 SHALL have port din0, output, DATA_WIDTH: SRAM write data, registered.
REQ-018 SHALL have port dout0, input, DATA_WIDTH: SRAM read data.

Function
REQ-019 Transfer SHALL occur when pN_valid && pN_ready at a rising edge; at most one port is ready per cycle.
REQ-020 Arbitration SHALL be combinational: only one valid port -> that port ready; both valid -> the port named by priority pointer prio is ready.
REQ-021 prio SHALL point to the non-granted port after every transfer and SHALL stay unchanged in cycles without a transfer.
REQ-022 pN_ready SHALL never be high while pN_valid is low.
REQ-023 The block SHALL accept one request per cycle with no bubble between back-to-back transfers.
REQ-024 For an in-range transfer at edge N, the block SHALL register csb0=0, web0=!we, addr0 and din0 at edge N, holding them for cycle N+1.
REQ-025 With no in-range transfer at edge N, csb0 SHALL be 1 during cycle N+1; web0, addr0 and din0 hold their previous values.
REQ-026 Out-of-range (addr >= NUM_WORDS) SHALL never drive csb0 low.
- Out-of-range write: silently dropped.
- Out-of-range read: response per REQ-028 with rsp_rdata=0 and pN_rsp_err=1.
REQ-027 A read accepted at edge N SHALL sample dout0 at edge N+2 into rsp_rdata, and pulse the originating pN_rsp_valid high for exactly cycle N+2.
REQ-028 The block SHALL carry requester id, read flag and error flag in a 2-stage shift pipeline; responses return in acceptance order.
REQ-029 Writes SHALL produce no response.
REQ-030 p0_rsp_valid and p1_rsp_valid SHALL never be high in the same cycle.
REQ-031 A read accepted one cycle after a write to the same address SHALL return the new data (the macro commits writes at the falling edge of the write cycle).
REQ-032 rsp_rdata SHALL hold its last value when no response is issued.

Reset
REQ-033 On rst0 high, asynchronously:
- csb0=1, web0=1, addr0=0, din0=0
- rsp_rdata=0, all pN_rsp_valid and pN_rsp_err=0
- prio=port 0
- response pipeline cleared
REQ-034 pN_ready SHALL be 0 while rst0 is high.
REQ-035 Reads in flight at reset assertion SHALL be discarded with no response after reset release.

Verification
REQ-036 Write p0 addr 3 data 0xDEAD_BEEF_0123_4567, then p1 read addr 3 -> p1_rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF01234567, p1_rsp_err=0.
REQ-037 Both ports hold read requests valid for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1 and responses return in the same order.
REQ-038 p0 read addr 20 and addr 31 -> csb0 stays 1 and p0_rsp_err=1 with rsp_rdata=0; p0 write addr 25 -> no SRAM access and no response.
REQ-039 p0 write addr 19 = 0x1, then the next cycle p0 read addr 19 -> rsp_rdata=0x1 (last word, back-to-back read-after-write).
REQ-040 Assert rst0 mid-cycle one cycle after a read is accepted -> csb0=1 immediately and no rsp_valid after release; the first post-reset contention grants p0.
